// File: rtl/inst_mem_loader_pkg.sv
// Shared widths, constants and state encoding for the instruction-memory loader.
package inst_mem_loader_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;  // also the NOP encoding
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_mem_array.sv
// Single-write-port word array with asynchronous read.
module inst_mem_array
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  waddr,
    input  logic [INST_DATA_W-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0]  raddr,
    output logic [INST_DATA_W-1:0] rdata
);

    logic [INST_DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Word write on the clock edge.
    // NOTE: storage has no reset; contents survive rst, only control state is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory responder filled at boot from a little-endian byte stream.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [INST_ADDR_W-1:0] addr,
    output logic [INST_DATA_W-1:0] inst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [7:0]             load_byte,
    output logic                   load_ready,
    input  logic                   load_end,
    output logic                   boot_done,
    output logic [DEPTH_LOG2:0]    words_loaded
);

    localparam int PTR_W = DEPTH_LOG2 + 1;

    state_t                 state, state_next;
    logic [PTR_W-1:0]       ptr, ptr_next, ptr_acc;
    logic [PTR_W-1:0]       words_q, words_next;
    logic [1:0]             byte_idx, byte_idx_next, idx_acc;
    logic [INST_DATA_W-1:0] buffer, buffer_next, asm_word;
    logic                   we;
    logic [INST_DATA_W-1:0] wdata;
    logic [INST_DATA_W-1:0] rdata;
    logic                   full, accept, in_range;
    logic                   unused_addr_bits;

    // ptr never exceeds 2^DEPTH_LOG2, so its MSB alone flags a full array.
    assign full       = ptr[DEPTH_LOG2];
    assign load_ready = (state == ST_LOAD) && !full;
    assign accept     = load_valid && load_ready;
    assign boot_done  = (state == ST_RUN);
    assign words_loaded = words_q;

    // Next-state, byte assembly and write-port control.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        byte_idx_next = byte_idx;
        buffer_next   = buffer;
        words_next    = words_q;
        we            = 1'b0;
        asm_word      = buffer;
        idx_acc       = byte_idx;
        ptr_acc       = ptr;

        // A byte accepted this cycle is folded in before any load_end flush.
        if (accept) begin
            asm_word[8*byte_idx +: 8] = load_byte;
            idx_acc                   = byte_idx + 2'd1;
        end
        wdata = asm_word;

        unique case (state)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    state_next    = ST_LOAD;
                    ptr_next      = '0;
                    byte_idx_next = '0;
                    buffer_next   = '0;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    // Restart wins over load_end and over a same-cycle byte.
                    ptr_next      = '0;
                    byte_idx_next = '0;
                    buffer_next   = '0;
                end else begin
                    byte_idx_next = idx_acc;
                    buffer_next   = asm_word;
                    if (accept && byte_idx == 2'd3) begin
                        we          = 1'b1;
                        ptr_acc     = ptr + PTR_W'(1);
                        buffer_next = '0;
                    end
                    // A completed word leaves idx_acc at 0, so at most one write per cycle.
                    if (load_end) begin
                        if (idx_acc != 2'd0 && !full) begin
                            we      = 1'b1;
                            ptr_acc = ptr + PTR_W'(1);
                        end
                        byte_idx_next = '0;
                        buffer_next   = '0;
                        words_next    = ptr_acc;
                        state_next    = ST_RUN;
                    end
                    ptr_next = ptr_acc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    // NOTE: non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            byte_idx <= '0;
            buffer   <= '0;
            words_q  <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            byte_idx <= byte_idx_next;
            buffer   <= buffer_next;
            words_q  <= words_next;
        end
    end

    inst_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(ptr[DEPTH_LOG2-1:0]),
        .wdata(wdata),
        .raddr(addr[DEPTH_LOG2+1:2]),
        .rdata(rdata)
    );

    // Byte offset within a word is irrelevant to word fetches.
    assign unused_addr_bits = ^addr[1:0];
    assign in_range = (addr[INST_ADDR_W-1:DEPTH_LOG2+2] == '0);
    assign inst = (ce == CHIP_ENABLE && state == ST_RUN && in_range) ? rdata : ZERO_WORD;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader with a small word-level reference model.
module tb_inst_mem_loader;

    localparam int DL2   = 2;
    localparam int DEPTH = 2**DL2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_end;
    logic        boot_done;
    logic [DL2:0] words_loaded;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: word contents by index, which indices have ever been written.
    logic [31:0] model_mem [DEPTH];
    bit          model_valid [DEPTH];
    int          model_words;
    logic [7:0]  stim [$];

    inst_mem_loader #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready), .load_end(load_end), .boot_done(boot_done),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Set fetch inputs a cycle clear of any edge and let inst settle.
    task automatic set_fetch(input logic c, input logic [31:0] a);
        tick;
        ce   = c;
        addr = a;
        #2;
    endtask

    // Apply a finished stream to the model: bytes beyond the array capacity are refused;
    // mode 0/1 ends the load (partial word zero-padded), mode 2 leaves it unterminated.
    task automatic model_apply(input int mode);
        int n, nw;
        n  = (stim.size() < 4*DEPTH) ? stim.size() : 4*DEPTH;
        nw = (mode == 2) ? n / 4 : (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            logic [31:0] w;
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4*k + j < n) w[8*j +: 8] = stim[4*k + j];
            model_mem[k]   = w;
            model_valid[k] = 1'b1;
        end
        if (mode != 2) model_words = nw;
    endtask

    // Drive load_start, the bytes in stim with random gaps, then load_end per mode.
    task automatic stream(input int gap_max, input int end_mode);
        int   accepted;
        logic exp_ready;
        accepted   = 0;
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                load_valid = 1'b0;
                load_byte  = 8'($urandom);
                tick;
            end
            load_valid = 1'b1;
            load_byte  = stim[i];
            load_end   = (end_mode == 1) && (i == stim.size() - 1);
            exp_ready  = (accepted < 4*DEPTH);
            vectors++;
            if (load_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL stream_ready byte %0d: load_ready=%b expected %b", i, load_ready, exp_ready);
            end
            vectors++;
            if (boot_done !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_boot byte %0d: boot_done=%b expected 0", i, boot_done);
            end
            if (exp_ready) accepted++;
            tick;
        end
        load_valid = 1'b0;
        load_end   = 1'b0;
        if (end_mode == 0) begin
            load_end = 1'b1;
            tick;
            load_end = 1'b0;
        end
        model_apply(end_mode);
    endtask

    // Compare RUN-state outputs and every written word against the model.
    task automatic test_readback(input string name);
        vectors++;
        if (boot_done !== 1'b1 || words_loaded !== (DL2+1)'(model_words)) begin
            miscompares++;
            $display("FAIL %s_status: boot_done=%b words_loaded=%0d expected 1/%0d",
                     name, boot_done, words_loaded, model_words);
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (model_valid[k]) begin
                set_fetch(1'b1, {28'd0, 2'(k), 2'($urandom)});
                vectors++;
                if (inst !== model_mem[k]) begin
                    miscompares++;
                    $display("FAIL %s_word%0d: inst=%h expected %h", name, k, inst, model_mem[k]);
                end
            end
        end
        set_fetch(1'b0, 32'd0);
        vectors++;
        if (inst !== 32'h0) begin
            miscompares++;
            $display("FAIL %s_ce_low: inst=%h expected 0", name, inst);
        end
        set_fetch(1'b1, 32'(4*DEPTH) + 32'($urandom_range(4*DEPTH-1, 0)));
        vectors++;
        if (inst !== 32'h0) begin
            miscompares++;
            $display("FAIL %s_out_of_range: addr=%h inst=%h expected 0", name, addr, inst);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b1; addr = 32'd0;
        load_start = 1'b0; load_valid = 1'b0; load_byte = 8'd0; load_end = 1'b0;
        repeat (3) tick;
        vectors++;
        if (inst !== 32'h0 || boot_done !== 1'b0 || load_ready !== 1'b0 || words_loaded !== '0) begin
            miscompares++;
            $display("FAIL reset_state: inst=%h boot_done=%b load_ready=%b words=%0d expected 0/0/0/0",
                     inst, boot_done, load_ready, words_loaded);
        end
        rst = 1'b0;
        tick;
        // Bytes and load_end in IDLE must be ignored.
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'($urandom);
            load_end   = 1'b1;
            tick;
        end
        load_valid = 1'b0;
        load_end   = 1'b0;
        tick;
        vectors++;
        if (boot_done !== 1'b0 || load_ready !== 1'b0 || words_loaded !== '0 || inst !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_ignore: boot_done=%b load_ready=%b words=%0d inst=%h expected 0/0/0/0",
                     boot_done, load_ready, words_loaded, inst);
        end
    endtask

    task automatic test_basic(input int gap_max, input string name);
        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        stream(gap_max, 0);
        vectors++;
        if (words_loaded !== 3'd2 || boot_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_status: words=%0d boot_done=%b expected 2/1", name, words_loaded, boot_done);
        end
        set_fetch(1'b1, 32'd0);
        vectors++;
        if (inst !== 32'h12345678) begin
            miscompares++;
            $display("FAIL %s_addr0: inst=%h expected 12345678", name, inst);
        end
        set_fetch(1'b1, 32'd4);
        vectors++;
        if (inst !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL %s_addr4: inst=%h expected deadbeef", name, inst);
        end
        set_fetch(1'b1, 32'd6);
        vectors++;
        if (inst !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL %s_addr6: inst=%h expected deadbeef", name, inst);
        end
        test_readback(name);
    endtask

    task automatic test_partial_same_cycle;
        stim = '{8'hAA, 8'hBB};
        stream(0, 1);
        set_fetch(1'b1, 32'd0);
        vectors++;
        if (inst !== 32'h0000BBAA || words_loaded !== 3'd1) begin
            miscompares++;
            $display("FAIL partial_same_cycle: inst=%h words=%0d expected 0000bbaa/1", inst, words_loaded);
        end
        test_readback("partial");
    endtask

    task automatic test_overflow;
        stim = {};
        for (int i = 1; i <= 20; i++) stim.push_back(8'(i));
        stream(1, 0);
        set_fetch(1'b1, 32'd12);
        vectors++;
        if (inst !== 32'h100F0E0D || words_loaded !== 3'd4) begin
            miscompares++;
            $display("FAIL overflow: mem3=%h words=%0d expected 100f0e0d/4", inst, words_loaded);
        end
        set_fetch(1'b1, 32'd16);
        vectors++;
        if (inst !== 32'h0) begin
            miscompares++;
            $display("FAIL overflow_addr16: inst=%h expected 0", inst);
        end
        test_readback("overflow");
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int len;
            len  = $urandom_range(20, 1);
            stim = {};
            for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
            stream($urandom_range(3, 0), $urandom_range(1, 0));
            test_readback("random");
        end
    endtask

    task automatic test_reload_reset;
        // Restart from RUN.
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        set_fetch(1'b1, 32'd0);
        vectors++;
        if (boot_done !== 1'b0 || inst !== 32'h0 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reload: boot_done=%b inst=%h load_ready=%b expected 0/0/1", boot_done, inst, load_ready);
        end
        // Reset mid-stream: one full word is written, the partial is lost.
        stim = {};
        for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
        stream(0, 2);
        rst = 1'b1;
        #1;
        model_words = 0;
        vectors++;
        if (boot_done !== 1'b0 || load_ready !== 1'b0 || words_loaded !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: boot_done=%b load_ready=%b words=%0d expected 0/0/0",
                     boot_done, load_ready, words_loaded);
        end
        tick;
        rst = 1'b0;
        tick;
        vectors++;
        if (load_ready !== 1'b0 || boot_done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: load_ready=%b boot_done=%b expected 0/0", load_ready, boot_done);
        end
        stim = {};
        for (int i = 0; i < 7; i++) stim.push_back(8'($urandom));
        stream(2, 0);
        test_readback("fresh");
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            model_mem[k]   = '0;
            model_valid[k] = 1'b0;
        end
        model_words = 0;
        test_reset;
        test_basic(0, "basic");
        test_partial_same_cycle;
        test_basic(3, "gaps");
        test_overflow;
        test_random;
        test_reload_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
